sa2_conv_core: RTL and testbench



---
 rtl/sa2_pkg.sv | 36 +++
 rtl/sa2_conv_core_pe.sv | 30 +++
 rtl/sa2_conv_core.sv | 121 ++++++++++++
 tb/tb_sa2_conv_core.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sa2_pkg.sv
// Shared constants and types for the 2x2 systolic 3x3 convolution tile.
// Tap k = 3*i + j indexes kernel row i / column j of the convolution window.
package sa2_pkg;

  localparam int DATA_W   = 8;
  localparam int PROD_W   = 16;
  localparam int ACC_W    = 20;
  localparam int N_TAPS   = 9;
  localparam int DONE_CNT = 12;

  typedef logic [3:0] cnt_t;
  typedef logic [1:0] skew_t;
  typedef skew_t [1:0][1:0] skew_map_t;

  // Skew of PE(r,c) is r+c: index [r][c].
  localparam skew_map_t SKEW = '{'{2'd2, 2'd1}, '{2'd1, 2'd0}};

  function automatic logic [1:0] tap_row(cnt_t k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      4'd6, 4'd7, 4'd8: tap_row = 2'd2;
      default:          tap_row = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(cnt_t k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      4'd2, 4'd5, 4'd8: tap_col = 2'd2;
      default:          tap_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sa2_conv_core_pe.sv
// Output-stationary MAC cell: accumulates weight*activation and passes the
// weight on to its neighbours one cycle later.
module sa2_pe
  import sa2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] act_in,
  input  logic              clr,
  input  logic              mac_en,
  output logic [DATA_W-1:0] w_out,
  output logic [ACC_W-1:0]  acc
);

  logic [PROD_W-1:0] prod;
  assign prod = w_in * act_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_out <= '0;
      acc   <= '0;
    end else begin
      w_out <= w_in;
      if (clr)         acc <= '0;
      else if (mac_en) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/sa2_conv_core.sv
// 2x2 systolic tile computing a 3x3 valid convolution of a 4x4 image.
// Define SA2_SATURATE_EN to clamp outputs at 255 instead of wrapping.
module sa2_conv_core
  import sa2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              active_sa2,
  input  logic [DATA_W-1:0] a11, a12, a13, a14,
  input  logic [DATA_W-1:0] a21, a22, a23, a24,
  input  logic [DATA_W-1:0] a31, a32, a33, a34,
  input  logic [DATA_W-1:0] a41, a42, a43, a44,
  input  logic [DATA_W-1:0] b11, b12, b13,
  input  logic [DATA_W-1:0] b21, b22, b23,
  input  logic [DATA_W-1:0] b31, b32, b33,
  output logic              done_sa2,
  output logic [DATA_W-1:0] c11, c12, c21, c22
);

  logic [3:0][3:0][DATA_W-1:0] img;
  logic [2:0][2:0][DATA_W-1:0] ker;
  logic [1:0][1:0][DATA_W-1:0] w_fwd;
  logic [1:0][1:0][ACC_W-1:0]  acc;
  logic [1:0][1:0][DATA_W-1:0] res;
  logic [1:0][1:0][DATA_W-1:0] c_q;
  logic [DATA_W-1:0]           w_head;
  logic                        clr;
  logic                        unused_acc;
  logic                        unused_w;
  cnt_t                        cnt;
  cnt_t                        tap0;

  assign img[0] = {a14, a13, a12, a11};
  assign img[1] = {a24, a23, a22, a21};
  assign img[2] = {a34, a33, a32, a31};
  assign img[3] = {a44, a43, a42, a41};
  assign ker[0] = {b13, b12, b11};
  assign ker[1] = {b23, b22, b21};
  assign ker[2] = {b33, b32, b31};

  assign clr = active_sa2 && (cnt == '0);

  // Kernel is rotated 180 degrees as it enters the array.
  assign tap0   = cnt - cnt_t'(1);
  assign w_head = ker[2 - int'(tap_row(tap0))][2 - int'(tap_col(tap0))];

  for (genvar r = 0; r < 2; r++) begin : g_row
    for (genvar c = 0; c < 2; c++) begin : g_col
      localparam int S = int'(SKEW[r][c]);
      cnt_t              tap;
      logic              mac_en;
      logic [DATA_W-1:0] w_in;
      logic [DATA_W-1:0] act;

      assign tap    = cnt - cnt_t'(S + 1);
      assign mac_en = active_sa2 && (int'(cnt) >= S + 1) && (int'(cnt) <= S + N_TAPS);
      // Activation uses the same skewed tap index as the arriving weight.
      assign act    = img[r + int'(tap_row(tap))][c + int'(tap_col(tap))];

      if (r == 0 && c == 0) begin : g_head
        assign w_in = w_head;
      end else if (c == 0) begin : g_down
        assign w_in = w_fwd[r-1][0];
      end else begin : g_right
        assign w_in = w_fwd[r][c-1];
      end

      sa2_pe u_pe (
        .clk    (clk),
        .rst    (rst),
        .w_in   (w_in),
        .act_in (act),
        .clr    (clr),
        .mac_en (mac_en),
        .w_out  (w_fwd[r][c]),
        .acc    (acc[r][c])
      );
    end
  end

  assign unused_w = ^w_fwd[1][1];

  always_comb begin
    res        = '0;
    unused_acc = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
`ifdef SA2_SATURATE_EN
        res[r][c] = (acc[r][c] > ACC_W'(8'hFF)) ? '1 : acc[r][c][DATA_W-1:0];
`else
        res[r][c]  = acc[r][c][DATA_W-1:0];
        unused_acc = unused_acc ^ (^acc[r][c][ACC_W-1:DATA_W]);
`endif
      end
    end
  end

  // Last MAC lands at cnt 11, so results are stable once cnt reaches 12.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      done_sa2 <= 1'b0;
      c_q      <= '0;
    end else if (!active_sa2) begin
      cnt      <= '0;
      done_sa2 <= 1'b0;
    end else begin
      if (cnt != cnt_t'(DONE_CNT)) cnt <= cnt + cnt_t'(1);
      if (cnt == cnt_t'(DONE_CNT)) begin
        c_q      <= res;
        done_sa2 <= 1'b1;
      end
    end
  end

  assign c11 = c_q[0][0];
  assign c12 = c_q[0][1];
  assign c21 = c_q[1][0];
  assign c22 = c_q[1][1];

endmodule

// File: tb/tb_sa2_conv_core.sv
// Directed bench for sa2_conv_core: hand-computed results, abort, restart and async reset.
module tb_sa2_conv_core;

`ifdef SA2_SATURATE_EN
  localparam int E11 = 192, E12 = 237, E21 = 255, E22 = 255, EMAX = 255;
`else
  localparam int E11 = 192, E12 = 237, E21 = 116, E22 = 161, EMAX = 9;
`endif

  logic       clk, rst, active_sa2, done_sa2;
  logic [7:0] a [4][4];
  logic [7:0] b [3][3];
  logic [7:0] c11, c12, c21, c22;
  int         vectors = 0;
  int         miscompares = 0;

  sa2_conv_core dut (
    .clk(clk), .rst(rst), .active_sa2(active_sa2),
    .a11(a[0][0]), .a12(a[0][1]), .a13(a[0][2]), .a14(a[0][3]),
    .a21(a[1][0]), .a22(a[1][1]), .a23(a[1][2]), .a24(a[1][3]),
    .a31(a[2][0]), .a32(a[2][1]), .a33(a[2][2]), .a34(a[2][3]),
    .a41(a[3][0]), .a42(a[3][1]), .a43(a[3][2]), .a44(a[3][3]),
    .b11(b[0][0]), .b12(b[0][1]), .b13(b[0][2]),
    .b21(b[1][0]), .b22(b[1][1]), .b23(b[1][2]),
    .b31(b[2][0]), .b32(b[2][1]), .b33(b[2][2]),
    .done_sa2(done_sa2), .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input int e11, input int e12, input int e21, input int e22);
    chk({tag, ".c11"}, {24'd0, c11}, e11);
    chk({tag, ".c12"}, {24'd0, c12}, e12);
    chk({tag, ".c21"}, {24'd0, c21}, e21);
    chk({tag, ".c22"}, {24'd0, c22}, e22);
  endtask

  task automatic load_seq();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r][c] = 8'(4 * r + c + 1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) b[i][j] = 8'(3 * i + j + 1);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r][c] = v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) b[i][j] = v;
  endtask

  initial begin
    rst = 1'b0;
    active_sa2 = 1'b0;
    load_seq();
    #12;
    chk("reset.done", {31'd0, done_sa2}, 0);
    chk_c("reset", 0, 0, 0, 0);

    // Run 1: A=1..16, B=1..9, done appears after exactly 13 active edges
    @(negedge clk);
    rst = 1'b1;
    active_sa2 = 1'b1;
    repeat (12) @(negedge clk);
    chk("run1.done_at12", {31'd0, done_sa2}, 0);
    @(negedge clk);
    chk("run1.done_at13", {31'd0, done_sa2}, 1);
    chk_c("run1", E11, E12, E21, E22);
    repeat (16) @(negedge clk);
    chk("run1.done_hold", {31'd0, done_sa2}, 1);
    chk_c("run1_hold", E11, E12, E21, E22);
    active_sa2 = 1'b0;
    @(negedge clk);
    chk("run1.done_drop", {31'd0, done_sa2}, 0);
    chk_c("run1_drop", E11, E12, E21, E22);

    // All-255 inputs: accumulator 585225
    fill(8'hFF);
    active_sa2 = 1'b1;
    repeat (13) @(negedge clk);
    chk("max.done", {31'd0, done_sa2}, 1);
    chk_c("max", EMAX, EMAX, EMAX, EMAX);
    active_sa2 = 1'b0;
    @(negedge clk);

    // Abort at the 6th active edge, then restart after one low cycle
    load_seq();
    active_sa2 = 1'b1;
    repeat (5) @(negedge clk);
    active_sa2 = 1'b0;
    @(negedge clk);
    chk("abort.done", {31'd0, done_sa2}, 0);
    chk_c("abort_hold", EMAX, EMAX, EMAX, EMAX);
    active_sa2 = 1'b1;
    repeat (12) @(negedge clk);
    chk("restart.done_at12", {31'd0, done_sa2}, 0);
    @(negedge clk);
    chk("restart.done_at13", {31'd0, done_sa2}, 1);
    chk_c("restart", E11, E12, E21, E22);

    // Async reset while done is high
    #2;
    rst = 1'b0;
    #1;
    chk("rst_done.done", {31'd0, done_sa2}, 0);
    chk_c("rst_done", 0, 0, 0, 0);

    // Single tap b33=1: picks out the top-left corner of each window
    fill(8'h00);
    load_seq();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) b[i][j] = 8'h00;
    b[2][2] = 8'd1;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("b33.done_at12", {31'd0, done_sa2}, 0);
    @(negedge clk);
    chk("b33.done_at13", {31'd0, done_sa2}, 1);
    chk_c("b33", 1, 2, 5, 6);

    // Async reset mid-run
    active_sa2 = 1'b0;
    @(negedge clk);
    active_sa2 = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.done", {31'd0, done_sa2}, 0);
    chk_c("rst_mid", 0, 0, 0, 0);
    active_sa2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
